// File: rtl/aes_pkg.sv
// Shared types for the AES read-data path: word/block types, packer states,
// and the byte mask applied to a partial final word.
package aes_pkg;

   typedef logic [127:0] block_t;
   typedef logic [31:0]  word_t;

   localparam int WORDS_PER_BLOCK = 4;

   typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} packer_state_t;

   // Keeps the upper tail bytes of a big-endian word; tail == 0 means a full word.
   function automatic word_t tail_mask(input logic [1:0] tail);
      word_t m;
      m = '1;
      if (tail != 2'd0) m = ~(32'hFFFF_FFFF >> (8 * tail));
      return m;
   endfunction

endpackage

// File: rtl/block_fifo.sv
// Small power-of-two FIFO of packed blocks plus their last tag.
// The head is read straight from the registered storage and forced to zero when empty.
module block_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 129,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic [W-1:0]  head
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/rx_block_packer.sv
// Packs big-endian 32-bit read words into zero-padded 128-bit blocks for the AES core,
// buffering finished blocks and tagging the final one of each transfer.
module rx_block_packer
   import aes_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int WORD_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [31:0]         size_bytes,
   input  logic [WORD_W-1:0]   word_in,
   input  logic                word_valid,
   output logic                word_ready,
   output logic [4*WORD_W-1:0] block_out,
   output logic                block_valid,
   input  logic                block_ready,
   output logic                block_last,
   output logic                busy,
   output logic                done
);

   localparam int CW = $clog2(DEPTH) + 1;

   packer_state_t state_q, state_d;

   logic [31:0] nwords_q, nblocks_q, words_q, blocks_q;
   logic [1:0]  tail_q, widx_q;
   word_t       lanes_q [WORDS_PER_BLOCK];

   logic          last_word, commit_pending, accept, push, pop;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [128:0]  fifo_head;
   word_t         word_m;
   block_t        blk;

   assign last_word      = (words_q == nwords_q - 32'd1);
   assign commit_pending = (widx_q == 2'd3) || last_word;
   // Only stall when the completing word would have nowhere to go.
   assign word_ready     = (state_q == FILL) && !(commit_pending && fifo_full);
   assign accept         = word_valid && word_ready;
   assign push           = accept && commit_pending;
   assign pop            = block_valid && block_ready;
   assign word_m         = last_word ? (word_in & tail_mask(tail_q)) : word_in;

   // Earlier lanes come from the partial block, later lanes stay zero.
   always_comb begin
      blk = '0;
      for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
         if (widx_q > 2'(k))       blk[127-32*k -: 32] = lanes_q[k];
         else if (widx_q == 2'(k)) blk[127-32*k -: 32] = word_m;
      end
   end

   block_fifo #(.DEPTH(DEPTH), .W(129)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({(blocks_q == nblocks_q - 32'd1), blk}),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   assign block_valid = !fifo_empty;
   assign block_out   = fifo_head[127:0];
   assign block_last  = fifo_head[128];
   assign busy        = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      case (state_q)
         IDLE:  if (start) state_d = (size_bytes == 32'd0) ? DONE : FILL;
         FILL:  if (accept && last_word) state_d = DRAIN;
         DRAIN: if (pop && block_last) begin
            state_d = IDLE;
            done    = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
            done    = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nwords_q  <= '0;
         nblocks_q <= '0;
         words_q   <= '0;
         blocks_q  <= '0;
         tail_q    <= '0;
         widx_q    <= '0;
         for (int k = 0; k < WORDS_PER_BLOCK; k++) lanes_q[k] <= '0;
      end else begin
         if (state_q == IDLE && start) begin
            nwords_q  <= (size_bytes + 32'd3) >> 2;
            nblocks_q <= (size_bytes + 32'd15) >> 4;
            tail_q    <= size_bytes[1:0];
            words_q   <= '0;
            blocks_q  <= '0;
            widx_q    <= '0;
         end
         if (accept) begin
            lanes_q[widx_q] <= word_m;
            words_q         <= words_q + 32'd1;
            widx_q          <= widx_q + 2'd1;
         end
         if (push) blocks_q <= blocks_q + 32'd1;
      end
   end

   logic unused_ok;
   assign unused_ok = ^fifo_count;

endmodule

// File: doc/rx_block_packer.md
Name: rx_block_packer

Overview:
- Sits between the AHB master's read-data path and the AES core input.
- Accepts 32-bit words fetched from memory, most-significant word first, and packs them into 128-bit blocks.
- Zero-pads the tail of the final block and buffers completed blocks in a small FIFO.
- Presents blocks to the AES controller over a valid/ready handshake, with a last-block flag derived from the programmed byte size.

Parameters:
- DEPTH, 2, number of 128-bit block entries in the output FIFO (power of two, ≥2).
- WORD_W, 32, input word width; block width is fixed at 4*WORD_W = 128.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; latches size_bytes and begins a transfer.
- size_bytes  input  32  total payload size in bytes, sampled on start.
- word_in  input  32  fetched data word, big-endian byte order (byte 0 = bits 31:24).
- word_valid  input  1  word_in valid this cycle.
- word_ready  output  1  packer accepts word_in this cycle.
- block_out  output  128  head FIFO entry; word 0 in bits 127:96.
- block_valid  output  1  FIFO non-empty.
- block_ready  input  1  consumer pops the head entry this cycle.
- block_last  output  1  head entry is the final block of the transfer.
- busy  output  1  transfer in progress (state != IDLE).
- done  output  1  one-cycle pulse when the final block is popped, or one cycle after start when size_bytes == 0.

Behaviour:
- Reset: state IDLE, FIFO empty, word index 0, all counters 0.
  - Every output is 0 after reset, including block_out.
- Derived values, latched on start:
  - nwords = ceil(size_bytes/4)
  - nblocks = ceil(size_bytes/16)
  - tail_bytes = size_bytes mod 4
  - All arithmetic is 32-bit unsigned; the 32-bit add overflow for sizes ≥ 0xFFFFFFF1 is out of spec.
- States:
  - IDLE: start with size_bytes == 0 → DONE; start with nonzero size → FILL. start is ignored outside IDLE.
  - FILL: accepts words. After the nwords-th word is accepted → DRAIN.
  - DRAIN: waits for the FIFO to empty. When the last block pops → IDLE, and done pulses in that same cycle.
  - DONE: single cycle; done = 1, then → IDLE.
- Word acceptance: a word is accepted when word_valid && word_ready. word_ready = (state == FILL) && !(commit_pending && count == DEPTH).
  - commit_pending means the next accepted word completes a block: word index == 3, or it is the nwords-th word.
  - word_ready has no combinational dependency on block_ready or word_valid.
- Packing: accepted word k of a block is written to lane k (lane 0 = bits 127:96).
  - Lanes after the final word of the transfer are forced to zero.
  - If the final word has tail_bytes != 0, only the upper tail_bytes bytes are kept; the remaining bytes are zeroed.
- Commit: the block is written into the FIFO in the same cycle the completing word is accepted.
  - Its last tag = (blocks committed == nblocks − 1).
  - Word index wraps 3 → 0.
- FIFO: pop when block_valid && block_ready.
  - A simultaneous commit and pop when count == DEPTH is not possible (word_ready is low); when count < DEPTH both happen and count is unchanged.
  - block_out and block_last always reflect the registered head entry, zero when empty.
- word_valid outside FILL is ignored; no error output.
- Reset mid-transfer discards all FIFO contents and partial words and returns to IDLE the next cycle; no done pulse is issued.
- Latency: the first block is valid one cycle after its 4th word is accepted.

Decomposition:
- Shared package aes_pkg:
  - typedef block_t (logic [127:0]) and word_t (logic [31:0]).
  - localparam WORDS_PER_BLOCK = 4.
  - enum packer_state_t {IDLE, FILL, DRAIN, DONE}.
- One sub-module: block_fifo.
  - Parameterised DEPTH, entries 129 bits wide (block plus last tag).
  - Ports push, pop, full, empty, count, head.
  - Synchronous active-high reset.
- The packer FSM, lane masking and counters stay in rx_block_packer.

Test Plan:
- Single block: start, size 16; words ABCD52C2, F9C6F303, 030F8303, 1AB61040; block_ready = 1 → one block ABCD52C2F9C6F303030F83031AB61040 with block_last = 1. done pulses on the pop; busy then falls.
- Tail padding:
  - Size 20, 5 words, 5th word DEADBEEF → 2nd block = DEADBEEF followed by 96 zero bits, block_last = 1.
  - Size 18, 5th word 11223344 → 2nd block = 11220000 then zeros.
- Backpressure: size 48, block_ready held 0 → word_ready falls while the 12th word is pending (FIFO holds 2 blocks). Raising block_ready for one cycle accepts the 12th word in the following cycle. The three blocks pop in order, and only the 3rd has block_last = 1.
- Zero size: start with size 0 → done = 1 exactly one cycle later, block_valid never asserts, busy high for one cycle.
- Reset mid-operation: assert rst after 6 of 8 words → next cycle block_valid = 0, busy = 0, word_ready = 0, no done pulse. A following size-16 transfer behaves as in the single-block case.
- Illegal stimulus: start pulsed during FILL, and word_valid asserted in IDLE → both are ignored; block contents and counts are unaffected.
